// File: rtl/fp_mult_pipe_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// small classification helpers reused by the FP datapath blocks.
package fp_mult_pipe_pkg;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_SUB  = 3'd1,
        CLS_NORM = 3'd2,
        CLS_INF  = 3'd3,
        CLS_NAN  = 3'd4
    } fp_class_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Subnormal operands are read as signed zero (denormals-are-zero).
    function automatic logic is_zero_like(input fp_class_e cls);
        return (cls == CLS_ZERO) || (cls == CLS_SUB);
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational operand unpack: splits {sign,exp,frac}, restores the hidden
// bit and classifies the operand.
module fp_unpack
    import fp_mult_pipe_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op,
    output logic                 sign,
    output logic [EXP_W-1:0]     exp,
    output logic [MAN_W:0]       man,
    output fp_class_e            cls,
    output logic                 snan
);

    logic [MAN_W-1:0] frac;
    logic             exp_ones;
    logic             exp_zero;
    logic             frac_zero;

    assign sign      = op[EXP_W+MAN_W];
    assign exp       = op[EXP_W+MAN_W-1 -: EXP_W];
    assign frac      = op[MAN_W-1:0];
    assign exp_ones  = &exp;
    assign exp_zero  = ~|exp;
    assign frac_zero = ~|frac;
    assign man       = {~exp_zero, frac};

    always_comb begin
        cls = CLS_NORM;
        if (exp_ones) begin
            cls = frac_zero ? CLS_INF : CLS_NAN;
        end else if (exp_zero) begin
            cls = frac_zero ? CLS_ZERO : CLS_SUB;
        end
    end

    // A NaN is signalling when the quiet bit (fraction MSB) is clear.
    assign snan = (cls == CLS_NAN) && !frac[MAN_W-1];

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier: S1 unpack/classify, S2 mantissa
// multiply and exponent sum, S3 normalise/round/pack, with stream back-pressure.
module fp_mult_pipe
    import fp_mult_pipe_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    // Handshake: a word moves on a port in any cycle where valid && ready are
    // both high; valid never depends on ready, and in_ready never on in_valid.
    logic s1_valid, s2_valid, s3_valid;
    logic s1_load, s2_load, s3_load;

    assign s3_load   = !s3_valid || out_ready;
    assign s2_load   = !s2_valid || s3_load;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s3_valid;

    logic             sa, sb, snan_a, snan_b;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0]   ma, mb;
    fp_class_e        cls_a, cls_b;

    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .op(a), .sign(sa), .exp(ea), .man(ma), .cls(cls_a), .snan(snan_a)
    );
    fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .op(b), .sign(sb), .exp(eb), .man(mb), .cls(cls_b), .snan(snan_b)
    );

    logic         sign_p, a_zero, b_zero, a_inf, b_inf;
    logic         sp_hit;
    logic [W-1:0] sp_res;
    logic [3:0]   sp_flags;

    assign sign_p = sa ^ sb;
    assign a_zero = is_zero_like(cls_a);
    assign b_zero = is_zero_like(cls_b);
    assign a_inf  = (cls_a == CLS_INF);
    assign b_inf  = (cls_b == CLS_INF);

    always_comb begin
        sp_hit   = 1'b1;
        sp_res   = '0;
        sp_flags = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            sp_res                 = QNAN;
            sp_flags[FLAG_INVALID] = snan_a || snan_b;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            sp_res                 = QNAN;
            sp_flags[FLAG_INVALID] = 1'b1;
        end else if (a_inf || b_inf) begin
            sp_res = {sign_p, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            sp_res = {sign_p, {(W-1){1'b0}}};
        end else begin
            sp_hit = 1'b0;
        end
    end

    logic             s1_special, s1_sign;
    logic [W-1:0]     s1_sp_res;
    logic [3:0]       s1_sp_flags;
    logic [EXP_W-1:0] s1_ea, s1_eb;
    logic [MAN_W:0]   s1_ma, s1_mb;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_special  <= 1'b0;
            s1_sign     <= 1'b0;
            s1_sp_res   <= '0;
            s1_sp_flags <= '0;
            s1_ea       <= '0;
            s1_eb       <= '0;
            s1_ma       <= '0;
            s1_mb       <= '0;
        end else if (s1_load) begin
            s1_valid    <= in_valid;
            s1_special  <= sp_hit;
            s1_sign     <= sign_p;
            s1_sp_res   <= sp_res;
            s1_sp_flags <= sp_flags;
            s1_ea       <= ea;
            s1_eb       <= eb;
            s1_ma       <= ma;
            s1_mb       <= mb;
        end
    end

    logic          s2_special, s2_sign;
    logic [W-1:0]  s2_sp_res;
    logic [3:0]    s2_sp_flags;
    logic [PW-1:0] s2_prod;
    logic [EW-1:0] s2_exp;

    // Exponent sum is kept two's complement so results below zero are visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid    <= 1'b0;
            s2_special  <= 1'b0;
            s2_sign     <= 1'b0;
            s2_sp_res   <= '0;
            s2_sp_flags <= '0;
            s2_prod     <= '0;
            s2_exp      <= '0;
        end else if (s2_load) begin
            s2_valid    <= s1_valid;
            s2_special  <= s1_special;
            s2_sign     <= s1_sign;
            s2_sp_res   <= s1_sp_res;
            s2_sp_flags <= s1_sp_flags;
            s2_prod     <= PW'(s1_ma) * PW'(s1_mb);
            s2_exp      <= {2'b00, s1_ea} + {2'b00, s1_eb} - EW'(BIAS);
        end
    end

    logic             norm, guard, sticky, round_up;
    logic [PW-1:0]    p_n;
    logic [MAN_W-1:0] mant;
    logic [MAN_W:0]   mant_r;
    logic [EW-1:0]    exp_f;
    logic [W-1:0]     pack_res;
    logic [3:0]       pack_flags;

    always_comb begin
        norm       = s2_prod[PW-1];
        p_n        = norm ? s2_prod : (s2_prod << 1);
        mant       = p_n[PW-2 -: MAN_W];
        guard      = p_n[PW-2-MAN_W];
        sticky     = |p_n[PW-3-MAN_W:0];
        round_up   = guard && (sticky || mant[0]);
        mant_r     = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
        exp_f      = s2_exp + {{(EW-1){1'b0}}, norm} + {{(EW-1){1'b0}}, mant_r[MAN_W]};
        pack_res   = {s2_sign, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
        pack_flags = '0;
        pack_flags[FLAG_INEXACT] = guard || sticky;
        if (s2_special) begin
            pack_res   = s2_sp_res;
            pack_flags = s2_sp_flags;
        end else if (!exp_f[EW-1] && exp_f >= EXP_MAX) begin
            pack_res   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags = '0;
            pack_flags[FLAG_OVERFLOW] = 1'b1;
            pack_flags[FLAG_INEXACT]  = 1'b1;
        end else if (exp_f[EW-1] || exp_f == '0) begin
            pack_res   = {s2_sign, {(W-1){1'b0}}};
            pack_flags = '0;
            pack_flags[FLAG_UNDERFLOW] = 1'b1;
            pack_flags[FLAG_INEXACT]   = 1'b1;
        end
    end

    // Flags clear whenever a bubble enters the output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid <= 1'b0;
            result   <= '0;
            flags    <= '0;
        end else if (s3_load) begin
            s3_valid <= s2_valid;
            result   <= pack_res;
            flags    <= s2_valid ? pack_flags : 4'b0000;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed bench for fp_mult_pipe (FP32): arithmetic, rounding, specials,
// saturation, back-pressure ordering and mid-flight reset.
module tb_fp_mult_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .BIAS(127)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks = n_checks + 1;
        assert (obs === expv) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One unstalled operation: accept, wait for the result, consume it.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic [31:0] er, input logic [3:0] ef);
        int lat;
        a = ta;
        b = tb_v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat = lat + 1;
        end
        check({tag, "_latency"}, lat, 32'd3);
        check({tag, "_result"}, result, er);
        check({tag, "_flags"}, {28'd0, flags}, {28'd0, ef});
        tick();
    endtask

    logic [31:0] vec_a [8];
    logic [31:0] vec_r [8];

    initial begin
        int idx, got, cyc;
        logic prev_stall;
        logic [31:0] held;

        vec_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                  32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        vec_r = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                  32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("mul_2x3", 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
        run_op("rne_sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        run_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
        run_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
        run_op("inf_x_zero", 32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000);
        run_op("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        run_op("neg_zero", 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
        run_op("snan", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_op("qnan", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
        run_op("daz_sub", 32'h00000001, 32'hC0000000, 32'h80000000, 4'b0000);
        run_op("rne_carry", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001);

        // Back-to-back stream with the sink stalled during cycles 2..7.
        idx = 0; got = 0; cyc = 0; prev_stall = 1'b0; held = '0;
        while (got < 8 && cyc < 40) begin
            in_valid  = (idx < 8);
            a         = (idx < 8) ? vec_a[idx] : 32'h0;
            b         = 32'h40000000;
            out_ready = !(cyc >= 2 && cyc <= 7);
            #1;
            if (prev_stall) check("stall_hold", result, held);
            if (cyc == 3 || cyc == 7) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("stream_order", result, exp_q.pop_front());
                    check("stream_flags", {28'd0, flags}, 32'd0);
                end
                got = got + 1;
            end
            prev_stall = out_valid && !out_ready;
            held = result;
            if (in_valid && in_ready) begin
                exp_q.push_back(vec_r[idx]);
                idx = idx + 1;
            end
            tick();
            cyc = cyc + 1;
        end
        in_valid = 1'b0;
        check("stream_sent", idx, 32'd8);
        check("stream_got", got, 32'd8);
        check("stream_q_empty", exp_q.size(), 32'd0);

        // Fill the pipe behind a stalled sink, then reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 32'h40400000;
        b = 32'h40400000;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        #1;
        check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_flags", {28'd0, flags}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        run_op("post_rst", 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
